// File: rtl/tx_serializer.sv
// UART-style frame serializer: start bit, LSB-first data, parity, stop bit.
// Each bit is held for CLOCKS_PER_BIT cycles; outputs are registered.
module tx_serializer #(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned CLOCKS_PER_BIT   = 16,
    parameter int unsigned PARITY_ODD       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic                        tx_done
);

    localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam logic             ODD_SEL  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [INPUT_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                        parity_q, parity_d;
    logic                        serial_d;
    logic                        done_d;
    logic                        bit_end;

    // Next-state, counters, shift register and registered-output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        serial_d = 1'b1;
        bit_end  = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shreg_d  = tx_data;
                    parity_d = (^tx_data) ^ ODD_SEL;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Line value follows the state being entered so the first start cycle
        // appears right after the accepting edge.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shreg_d[0];
            PARITY:  serial_d = parity_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            serial_out <= serial_d;
            tx_ready   <= (state_d == IDLE);
            tx_busy    <= (state_d != IDLE);
            tx_done    <= done_d;
        end
    end

    // Structural invariants of the serializer
    a_state_legal : assert property (@(posedge clk) disable iff (!reset)
        state_q inside {IDLE, START, DATA, PARITY, STOP});
    a_ready_busy : assert property (@(posedge clk) disable iff (!reset)
        tx_ready == !tx_busy);
    a_ready_idle : assert property (@(posedge clk) disable iff (!reset)
        tx_ready == (state_q == IDLE));
    a_line_high : assert property (@(posedge clk) disable iff (!reset)
        (state_q == IDLE || state_q == STOP) |-> serial_out);

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: frame contents, timing, parity modes,
// back-to-back frames, ignored mid-frame requests and asynchronous reset.
module tb_tx_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, serial_out, tx_busy, tx_done;
    logic [7:0] odd_tx_data;
    logic       odd_tx_valid;
    logic       odd_tx_ready, odd_serial_out, odd_tx_busy, odd_tx_done;

    int n_checks = 0;
    int n_pass   = 0;

    tx_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    tx_serializer #(.PARITY_ODD(1)) dut_odd (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (odd_tx_data),
        .tx_valid   (odd_tx_valid),
        .tx_ready   (odd_tx_ready),
        .serial_out (odd_serial_out),
        .tx_busy    (odd_tx_busy),
        .tx_done    (odd_tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Offer one byte on the next rising edge; return #1 after the accepting edge.
    task automatic send(input bit odd, input logic [7:0] data, input bit keep_valid);
        @(negedge clk);
        if (odd) begin odd_tx_data = data; odd_tx_valid = 1'b1; end
        else     begin tx_data = data;     tx_valid = 1'b1;     end
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            if (odd) odd_tx_valid = 1'b0;
            else     tx_valid = 1'b0;
        end
    endtask

    // Sample every cycle of a frame starting at cycle 1 after acceptance,
    // then check the tx_done cycle (cycle 177).
    task automatic expect_frame(input string tag, input bit odd, input logic [7:0] data,
                                input logic par, input bit glitch);
        logic [10:0] bits;
        int          done_seen;
        logic        so, dn;
        bits      = {1'b1, par, data, 1'b0};
        done_seen = 0;
        for (int b = 0; b < 11; b++) begin
            int good;
            good = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                so = odd ? odd_serial_out : serial_out;
                dn = odd ? odd_tx_done : tx_done;
                if (so === bits[b]) good++;
                if (dn !== 1'b0) done_seen++;
                if (b == 0 && c == 0)
                    check($sformatf("%s busy_c1", tag), 32'(odd ? odd_tx_busy : tx_busy), 32'd1);
                if (glitch && b == 4 && c == 0) begin tx_valid = 1'b1; tx_data = 8'h00; end
                if (glitch && b == 4 && c == 1) tx_valid = 1'b0;
            end
            check($sformatf("%s bit%0d_cycles", tag, b), 32'(good), 32'd16);
        end
        check($sformatf("%s early_done", tag), 32'(done_seen), 32'd0);
        @(negedge clk);
        check($sformatf("%s done_c177", tag), 32'(odd ? odd_tx_done : tx_done), 32'd1);
        check($sformatf("%s ready_c177", tag), 32'(odd ? odd_tx_ready : tx_ready), 32'd1);
        check($sformatf("%s line_c177", tag), 32'(odd ? odd_serial_out : serial_out), 32'd1);
    endtask

    // Count idle cycles with line high, ready set, and no done pulse.
    task automatic expect_idle(input string tag, input int cycles);
        int good;
        good = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (serial_out === 1'b1 && tx_ready === 1'b1 && tx_busy === 1'b0 && tx_done === 1'b0)
                good++;
        end
        check(tag, 32'(good), 32'(cycles));
    endtask

    initial begin
        reset        = 1'b1;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        odd_tx_data  = 8'h00;
        odd_tx_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst serial_out", 32'(serial_out), 32'd1);
        check("rst tx_ready",   32'(tx_ready),   32'd1);
        check("rst tx_busy",    32'(tx_busy),    32'd0);
        check("rst tx_done",    32'(tx_done),    32'd0);
        check("rst odd_serial", 32'(odd_serial_out), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 0xA5, even parity 0, done exactly one cycle
        send(1'b0, 8'hA5, 1'b0);
        expect_frame("a5", 1'b0, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("a5 done_one_cycle", 32'(tx_done), 32'd0);

        // 0x07: even parity 1, odd parity 0
        send(1'b0, 8'h07, 1'b0);
        expect_frame("07even", 1'b0, 8'h07, 1'b1, 1'b0);
        send(1'b1, 8'h07, 1'b0);
        expect_frame("07odd", 1'b1, 8'h07, 1'b0, 1'b0);

        // Back-to-back with tx_valid held: 0x00 then 0xFF
        send(1'b0, 8'h00, 1'b1);
        tx_data = 8'hFF;
        expect_frame("b2b00", 1'b0, 8'h00, 1'b0, 1'b0);
        expect_frame("b2bff", 1'b0, 8'hFF, 1'b0, 1'b0);
        tx_valid = 1'b0;
        expect_idle("b2b idle_after", 20);

        // Mid-frame request and data change are ignored
        send(1'b0, 8'h3C, 1'b0);
        expect_frame("3c", 1'b0, 8'h3C, 1'b0, 1'b1);
        expect_idle("3c no_second_frame", 30);

        // Asynchronous reset during data bit 3, then fresh frame
        send(1'b0, 8'h96, 1'b0);
        repeat (70) @(negedge clk);
        check("abort pre_busy", 32'(tx_busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort serial_out", 32'(serial_out), 32'd1);
        check("abort tx_ready",   32'(tx_ready),   32'd1);
        check("abort tx_busy",    32'(tx_busy),    32'd0);
        check("abort tx_done",    32'(tx_done),    32'd0);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        check("abort held_done", 32'(tx_done), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        expect_frame("5a_after_rst", 1'b0, 8'h5A, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
